ahb_cmd_master: RTL and testbench

- Single-outstanding AHB-Lite master that sits directly upstream of the on-chip single-port RAM and drives its HADDR/HWRITE/HWDATA and samples its HRDATA/HREADY.
- Accepts one word command (read or write) from the JTAG-side command logic over a valid/ready handshake.
- Runs the address phase and the data phase, honouring HREADY wait states, and returns read data or error status over a valid/ready response channel.
- Includes a wait-state timeout and a range check so the JTAG path can never hang on the bus.

---
 rtl/ahb_cmd_master_if.sv | 40 ++++
 rtl/ahb_cmd_master.sv | 125 ++++++++++++
 tb/tb_ahb_cmd_master.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_cmd_master_if.sv
// Command / response / AHB-Lite signal bundle for ahb_cmd_master.
// master modport: the command master; slave modport: the JTAG command side
// plus the RAM side.
interface ahb_cmd_master_if;
  // command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  // AHB-Lite
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           HRDATA, HREADY, HRESP,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           HADDR, HWRITE, HTRANS, HSIZE, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           HRDATA, HREADY, HRESP,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           HADDR, HWRITE, HTRANS, HSIZE, HWDATA
  );
endinterface

// File: rtl/ahb_cmd_master.sv
// Single-outstanding AHB-Lite master: one word command in, one response out.
// Latency: accept at edge N -> rsp_valid from N+3 (+wait states); range error N+1.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready.
// Ports: clk, rst_n (async active-low); bus = cmd/rsp handshakes + AHB master side.
// All outputs come from registers or from the state register alone.
module ahb_cmd_master #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ahb_cmd_master_if.master   bus
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;
  logic        to_q,    to_d;
  logic [7:0]  wait_q,  wait_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    to_d    = to_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          write_d = bus.cmd_write;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          to_d    = 1'b0;
          // Out-of-range commands never reach the bus.
          if (bus.cmd_addr >= DEPTH_W) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (bus.HREADY) begin
          wait_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Completion wins over abort when both happen in the same cycle.
        if (bus.HREADY) begin
          rdata_d = (!write_q && !bus.HRESP) ? bus.HRDATA : '0;
          err_d   = bus.HRESP;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (wait_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // HTRANS decodes straight from the state register so an async reset
  // drops NONSEQ immediately.
  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.HTRANS      = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign bus.HSIZE       = 3'b010;
  assign bus.HADDR       = addr_q;
  assign bus.HWRITE      = write_q;
  assign bus.HWDATA      = wdata_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = to_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: directed plus random commands against a
// word-level reference model and a wait-state-programmable RAM slave.
module tb_ahb_cmd_master;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ahb_cmd_master_if bus();

  ahb_cmd_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // RAM contents as seen by the slave, and the model's idea of the RAM
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  // slave plan for the current command
  int          plan_aw, plan_dw;
  logic        plan_resp;
  logic        plan_write;
  logic [31:0] plan_addr, plan_wdata;
  int          nonseq_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // AHB slave: acts at negedge, drives HREADY for the next posedge
  initial begin : slave
    bit          in_addr, in_data, s_write;
    int          aw_left, dw_left;
    logic [4:0]  s_addr;
    in_addr = 0; in_data = 0; s_write = 0; aw_left = 0; dw_left = 0; s_addr = '0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        in_addr = 0; in_data = 0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end else begin
        if (in_data && bus.rsp_valid) in_data = 0; // transfer aborted
        bus.HRESP  = 1'b0;
        bus.HRDATA = $urandom;
        if (in_data) begin
          if (s_write) check("hwdata_held", bus.HWDATA, plan_wdata);
          if (dw_left > 0) begin
            bus.HREADY = 1'b0;
            dw_left--;
          end else begin
            bus.HREADY = 1'b1;
            in_data    = 0;
            bus.HRESP  = plan_resp;
            if (!plan_resp) begin
              if (s_write) mem[s_addr] = bus.HWDATA;
              else         bus.HRDATA = mem[s_addr];
            end
          end
        end else if (bus.HTRANS == 2'b10) begin
          nonseq_cnt++;
          if (!in_addr) begin
            in_addr = 1;
            aw_left = plan_aw;
            check("haddr", bus.HADDR, plan_addr);
            check("hwrite", 32'(bus.HWRITE), 32'(plan_write));
            check("hsize", 32'(bus.HSIZE), 32'h2);
          end
          if (aw_left > 0) begin
            bus.HREADY = 1'b0;
            aw_left--;
          end else begin
            bus.HREADY = 1'b1;
            in_addr = 0;
            in_data = 1;
            dw_left = plan_dw;
            s_addr  = bus.HADDR[4:0];
            s_write = bus.HWRITE;
          end
        end else begin
          bus.HREADY = 1'b1;
        end
      end
    end
  end

  // Present one command and return just after the accepting edge.
  task automatic accept_cmd(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input int aw, input int dw, input logic resp);
    @(negedge clk);
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'h1);
    plan_aw = aw; plan_dw = dw; plan_resp = resp;
    plan_write = w; plan_addr = a; plan_wdata = wd;
    nonseq_cnt = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = wd;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom); bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom;
  endtask

  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input int aw, input int dw, input logic resp, input int rdly);
    int          lat, k, e_ns;
    logic [31:0] e_rd;
    logic        e_err, e_to;
    // reference model: response and latency straight from the rules
    if (a >= DEPTH) begin
      lat = 1; e_err = 1; e_to = 0; e_rd = 0; e_ns = 0;
    end else if (dw >= TIMEOUT) begin
      lat = 2 + aw + TIMEOUT; e_err = 1; e_to = 1; e_rd = 0; e_ns = 1 + aw;
    end else begin
      lat = 3 + aw + dw; e_err = resp; e_to = 0; e_ns = 1 + aw;
      e_rd = (w || resp) ? 32'h0 : ref_mem[a[4:0]];
      if (w && !resp) ref_mem[a[4:0]] = wd;
    end

    accept_cmd(w, a, wd, aw, dw, resp);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.rsp_valid && k < 200);
    check("latency", 32'(k), 32'(lat));
    check("rsp_rdata", bus.rsp_rdata, e_rd);
    check("rsp_err", 32'(bus.rsp_err), 32'(e_err));
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'(e_to));
    check("cmd_ready_resp", 32'(bus.cmd_ready), 32'h0);

    for (int i = 0; i < rdly; i++) begin
      bus.cmd_valid = (i == 0); bus.cmd_addr = 32'd1; bus.cmd_write = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("bp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_rdata", bus.rsp_rdata, e_rd);
      check("bp_err", 32'(bus.rsp_err), 32'(e_err));
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    end
    check("nonseq_cycles", 32'(nonseq_cnt), 32'(e_ns));

    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_drop", 32'(bus.rsp_valid), 32'h0);
    check("back_idle", 32'(bus.cmd_ready), 32'h1);
  endtask

  // Reset in the middle of a transfer; no response may follow.
  task automatic reset_mid(input int aw, input int dw, input int cycles_in);
    accept_cmd(1'b0, 32'd9, 32'h0, aw, dw, 1'b0);
    repeat (cycles_in) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_htrans", 32'(bus.HTRANS), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_rsp", 32'(bus.rsp_valid), 32'h0);
    end
  endtask

  initial begin : main
    logic [31:0] ra;
    int          rdw, r;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h0101_0101 * i;
      ref_mem[i] = 32'h0101_0101 * i;
    end
    plan_aw = 0; plan_dw = 0; plan_resp = 0; plan_write = 0;
    plan_addr = 0; plan_wdata = 0; nonseq_cnt = 0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_haddr", bus.HADDR, 32'h0);
    check("reset_hwrite", 32'(bus.HWRITE), 32'h0);
    check("reset_hwdata", bus.HWDATA, 32'h0);
    check("reset_htrans", 32'(bus.HTRANS), 32'h0);
    check("reset_hsize", 32'(bus.HSIZE), 32'h2);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("reset_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", 32'(bus.cmd_ready), 32'h1);

    // zero-wait write then read back
    run_cmd(1'b1, 32'd5, 32'hDEAD_BEEF, 0, 0, 1'b0, 0);
    run_cmd(1'b0, 32'd5, 32'h0, 0, 0, 1'b0, 0);
    // data-phase wait states
    run_cmd(1'b1, 32'd7, 32'h1234_5678, 0, 0, 1'b0, 0);
    run_cmd(1'b0, 32'd7, 32'h0, 0, 4, 1'b0, 0);
    // timeout boundary: one short of abort, then abort, then normal again
    run_cmd(1'b0, 32'd3, 32'h0, 0, TIMEOUT - 1, 1'b0, 0);
    run_cmd(1'b0, 32'd3, 32'h0, 0, TIMEOUT, 1'b0, 0);
    run_cmd(1'b0, 32'd5, 32'h0, 0, 0, 1'b0, 0);
    // range checks
    run_cmd(1'b0, 32'd32, 32'h0, 0, 0, 1'b0, 0);
    run_cmd(1'b1, 32'hFFFF_FFFF, 32'hAAAA_5555, 0, 0, 1'b0, 0);
    run_cmd(1'b0, 32'd31, 32'h0, 0, 0, 1'b0, 0);
    // bus error on read and on write (write must not land)
    run_cmd(1'b0, 32'd5, 32'h0, 0, 0, 1'b1, 0);
    run_cmd(1'b1, 32'd6, 32'hCAFE_F00D, 0, 2, 1'b1, 0);
    run_cmd(1'b0, 32'd6, 32'h0, 0, 0, 1'b0, 0);
    // address-phase waits and response backpressure
    run_cmd(1'b0, 32'd5, 32'h0, 1, 1, 1'b0, 5);
    // reset in ADDR and in DATA
    reset_mid(4, 0, 2);
    reset_mid(0, 10, 3);
    run_cmd(1'b0, 32'd7, 32'h0, 0, 0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      ra = (r == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 1));
      r  = $urandom_range(0, 11);
      rdw = (r == 11) ? TIMEOUT + 2 : (r == 10) ? TIMEOUT - 1 : $urandom_range(0, 3);
      run_cmd(1'($urandom), ra, $urandom, $urandom_range(0, 2), rdw,
              ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end
endmodule
